muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the MIPS231 datapath. It sits beside the combinational `alu` and executes MULT, MULTU, DIV and DIVU over `WIDTH` cycles into the architectural HI/LO registers. It also supports MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO. A busy/done handshake lets the controller stall while an operation is in flight.

---
 rtl/muldiv.sv | 153 +++++++++++++++
 tb/tb_muldiv.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, WIDTH cycles per operation.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             z
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [0:0]    S_IDLE = 1'b0;
    localparam logic [0:0]    S_RUN  = 1'b1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             op_div;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH-1:0] a_orig;
    logic             neg_res;
    logic             neg_rem;
    logic             b_zero;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               last;

    assign busy = (state == S_RUN);
    assign z    = (lo == '0);
    assign last = (cnt == LAST);

    // Signed ops work on magnitudes; the signs are re-applied on the last step.
    always_comb begin
        a_neg = ~mdop[0] & A[WIDTH-1];
        b_neg = ~mdop[0] & B[WIDTH-1];
        a_abs = a_neg ? -A : A;
        b_abs = b_neg ? -B : B;
    end

    // acc_hi is the partial product or running remainder; acc_lo holds the
    // multiplier (shifted out LSB first) or dividend/quotient (shifted MSB first).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, bmag} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, bmag};
        nxt_hi    = mul_sum[WIDTH:1];
        nxt_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (op_div) begin
            if (!div_diff[WIDTH]) begin
                nxt_hi = div_diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Most-negative / -1 needs no special case: its magnitude quotient already
    // has the most-negative bit pattern and the remainder is zero.
    always_comb begin
        prod     = {nxt_hi, nxt_lo};
        prod_fix = neg_res ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (op_div) begin
            if (b_zero) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -nxt_hi : nxt_hi;
                res_lo = neg_res ? -nxt_lo : nxt_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_div  <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            bmag    <= '0;
            a_orig  <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    state   <= S_RUN;
                    cnt     <= '0;
                    op_div  <= mdop[1];
                    acc_hi  <= '0;
                    acc_lo  <= a_abs;
                    bmag    <= b_abs;
                    a_orig  <= A;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    b_zero  <= (B == '0);
                    dz      <= 1'b0;
                end else begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
            end else begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    dz    <= op_div & b_zero;
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed test-plan cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   mdop;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         z;

    int errors = 0;
    int checks = 0;

    muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model from the architectural definition of each instruction.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edz);
        int sa;
        int sb;
        longint p;
        longint unsigned pu;
        sa  = a;
        sb  = b;
        edz = 1'b0;
        case (op)
            2'b00: begin
                p  = longint'(sa) * longint'(sb);
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                pu = 64'(a) * 64'(b);
                eh = pu[63:32];
                el = pu[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    eh  = a;
                    el  = 32'hFFFF_FFFF;
                    edz = 1'b1;
                end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'd0;
                    el = 32'h8000_0000;
                end else if (op == 2'b10) begin
                    el = sa / sb;
                    eh = sa % sb;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    // Starts an op at the current negedge (so consecutive calls are back-to-back
    // through the done cycle) and returns at the negedge of the done cycle.
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit withWrite, input bit poke);
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] oldh;
        logic [31:0] oldl;
        logic        edz;
        int          cycles;
        bit          held;
        model(op, a, b, eh, el, edz);
        oldh  = hi;
        oldl  = lo;
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        if (withWrite) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start  = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        cycles = 0;
        held   = 1'b1;
        while (busy === 1'b1 && cycles < 200) begin
            if (hi !== oldh || lo !== oldl || done !== 1'b0) held = 1'b0;
            if (poke && cycles == 4) begin
                start = 1'b1;
                mdop  = 2'b00;
                A     = 32'd7;
                B     = 32'd9;
            end else if (poke && cycles == 9) begin
                start = 1'b0;
                hi_we = 1'b1;
                wdata = 32'h5555_AAAA;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        hi_we = 1'b0;
        checkOutput({tag, " latency"}, 64'(cycles), 64'(W));
        checkOutput({tag, " hold"}, 64'(held), 64'd1);
        checkOutput({tag, " done"}, 64'(done), 64'd1);
        checkOutput({tag, " hi"}, 64'(hi), 64'(eh));
        checkOutput({tag, " lo"}, 64'(lo), 64'(el));
        checkOutput({tag, " dz"}, 64'(dz), 64'(edz));
        checkOutput({tag, " z"}, 64'(z), 64'(el == 32'd0));
    endtask

    task automatic mtWrite(input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clk);
        hi_we = wh;
        lo_we = wl;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        bit          sawDone;
        reset = 1'b1;
        start = 1'b0;
        mdop  = 2'b00;
        A     = '0;
        B     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset dz", 64'(dz), 64'd0);
        checkOutput("reset z", 64'(z), 64'd1);

        mtWrite(1'b1, 1'b1, 32'hCAFE_0001);
        checkOutput("mt both hi", 64'(hi), 64'hCAFE_0001);
        checkOutput("mt both lo", 64'(lo), 64'hCAFE_0001);
        mtWrite(1'b0, 1'b1, 32'd0);
        checkOutput("mtlo0 lo", 64'(lo), 64'd0);
        checkOutput("mtlo0 hi", 64'(hi), 64'hCAFE_0001);
        checkOutput("mtlo0 z", 64'(z), 64'd1);

        @(negedge clk);
        applyStimulus("mult", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("done pulse", 64'(done), 64'd0);
        applyStimulus("multu ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus("mult ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        applyStimulus("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus("divu dz", 2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        applyStimulus("div dz", 2'b10, 32'h8765_4321, 32'd0, 1'b0, 1'b0);
        applyStimulus("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus("handshake", 2'b01, 32'd2, 32'd3, 1'b1, 1'b1);
        applyStimulus("b2b", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            applyStimulus($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        mtWrite(1'b1, 1'b1, 32'h0BAD_F00D);
        @(negedge clk);
        start = 1'b1;
        mdop  = 2'b11;
        A     = 32'd1000;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("midrst busy before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst hi", 64'(hi), 64'd0);
        checkOutput("midrst lo", 64'(lo), 64'd0);
        checkOutput("midrst busy", 64'(busy), 64'd0);
        checkOutput("midrst z", 64'(z), 64'd1);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("midrst no done", 64'(sawDone), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
